// File: rtl/wb_ctrl_pipe.sv
// wb_ctrl_pipe: write-back control bundle pipeline.
//
// Carries the WB control bundle ({mem_or_reg, byte_word, reg_write} by
// default) from ID/EXE through DEPTH register stages to the write-back point.
// The pipeline supports a global stall, per-stage flush (bubble insertion),
// valid tracking, per-stage reg-write taps for hazard detection, and an
// occupancy count.
//
// Ports:
//   clk            pipeline clock, rising edge
//   rst            synchronous reset, active-high
//   in_valid       in_ctrl carries a real instruction
//   in_ctrl        WB control bundle from ID/EXE
//   stall          hold every stage
//   flush          bit i clears stage i at the current edge
//   out_valid      stage DEPTH-1 holds a valid instruction
//   out_ctrl       stage DEPTH-1 bundle (zero when out_valid=0)
//   stage_valid    per-stage valid bits, bit 0 is the youngest
//   tap_reg_write  per-stage valid AND reg-write bit
//   occupancy      number of valid stages, 0..DEPTH
//
// Legal DEPTH range is 1..8. REGW_BIT must be below CTRL_W.
module wb_ctrl_pipe #(
  parameter int unsigned CTRL_W   = 3,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned REGW_BIT = 0,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic [DEPTH-1:0]  flush,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DEPTH-1:0]  stage_valid,
  output logic [DEPTH-1:0]  tap_reg_write,
  output logic [CNT_W-1:0]  occupancy
);

  // Per-stage state. Invariant: a clear valid bit always pairs with a zero
  // bundle, so bubbles never carry reg_write=1.
  logic [DEPTH-1:0]             v_q;
  logic [DEPTH-1:0]             v_d;
  logic [DEPTH-1:0][CTRL_W-1:0] c_q;
  logic [DEPTH-1:0][CTRL_W-1:0] c_d;
  logic [DEPTH-1:0]             tap_q;
  logic [DEPTH-1:0]             tap_d;
  logic [CNT_W-1:0]             occ_q;
  logic [CNT_W-1:0]             occ_d;

  // Value each stage would load when advancing.
  logic [DEPTH-1:0]             src_v;
  logic [DEPTH-1:0][CTRL_W-1:0] src_c;

  // Gate the incoming bundle with in_valid so an unknown in_ctrl on a
  // bubble cycle can never reach the stage registers.
  logic [CTRL_W-1:0] in_gated;
  assign in_gated = in_valid ? in_ctrl : '0;

  // Stage sources: stage 0 takes the gated input, every other stage takes
  // the pre-edge value of the stage before it.
  for (genvar g = 0; g < DEPTH; g++) begin : g_src
    if (g == 0) begin : g_head
      assign src_v[g] = in_valid;
      assign src_c[g] = in_gated;
    end else begin : g_body
      assign src_v[g] = v_q[g-1];
      assign src_c[g] = c_q[g-1];
    end
  end

  // Next-state per stage: flush > stall > advance (reset handled in the
  // register). A flushed stage still feeds its old value forward, because
  // src_* reads the pre-edge registers.
  always_comb begin
    v_d = v_q;
    c_d = c_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (flush[i]) begin
        v_d[i] = 1'b0;
        c_d[i] = '0;
      end else if (!stall) begin
        v_d[i] = src_v[i];
        c_d[i] = src_c[i];
      end
    end
  end

  // Taps and occupancy are computed from next state so they can be
  // registered alongside the stages.
  always_comb begin
    tap_d = '0;
    occ_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      tap_d[i] = v_d[i] & c_d[i][REGW_BIT];
      occ_d    = occ_d + CNT_W'(v_d[i]);
    end
  end

  // Stage, tap and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      tap_q <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      tap_q <= tap_d;
      occ_q <= occ_d;
    end
  end

  assign out_valid     = v_q[DEPTH-1];
  assign out_ctrl      = c_q[DEPTH-1];
  assign stage_valid   = v_q;
  assign tap_reg_write = tap_q;
  assign occupancy     = occ_q;

  // Occupancy can never exceed the stage count.
  a_occ_bound : assert property (@(posedge clk) disable iff (rst)
    occ_q <= CNT_W'(DEPTH));

  // Bubbles always hold an all-zero bundle.
  for (genvar g = 0; g < DEPTH; g++) begin : g_inv
    a_bubble_zero : assert property (@(posedge clk) disable iff (rst)
      !v_q[g] |-> (c_q[g] == '0));
  end

endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// Self-checking bench for wb_ctrl_pipe: directed scenarios on a DEPTH=2,
// CTRL_W=3 instance plus a randomised sweep of DEPTH=1/4/8, CTRL_W=5
// instances against a stage-list reference model.
module tb_wb_ctrl_pipe;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Directed DUT (DEPTH=2, CTRL_W=3)
  logic       rst;
  logic       in_valid;
  logic [2:0] in_ctrl;
  logic       stall;
  logic [1:0] flush;
  logic       out_valid;
  logic [2:0] out_ctrl;
  logic [1:0] stage_valid;
  logic [1:0] tap_reg_write;
  logic [1:0] occupancy;

  wb_ctrl_pipe #(.CTRL_W(3), .DEPTH(2), .REGW_BIT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .stall(stall), .flush(flush), .out_valid(out_valid), .out_ctrl(out_ctrl),
    .stage_valid(stage_valid), .tap_reg_write(tap_reg_write),
    .occupancy(occupancy)
  );

  // Snapshot {out_valid, out_ctrl, stage_valid, tap_reg_write, occupancy}
  wire [9:0] snap = {out_valid, out_ctrl, stage_valid, tap_reg_write, occupancy};
  logic [9:0] exp;

  // Sweep DUTs share stimulus; each sees the low DEPTH bits of sw_flush.
  logic       sw_rst;
  logic       sw_valid;
  logic [4:0] sw_ctrl;
  logic       sw_stall;
  logic [7:0] sw_flush;

  logic       d1_ov, d4_ov, d8_ov;
  logic [4:0] d1_oc, d4_oc, d8_oc;
  logic [0:0] d1_sv, d1_tap;
  logic [3:0] d4_sv, d4_tap;
  logic [7:0] d8_sv, d8_tap;
  logic [0:0] d1_occ;
  logic [2:0] d4_occ;
  logic [3:0] d8_occ;

  wb_ctrl_pipe #(.CTRL_W(5), .DEPTH(1), .REGW_BIT(0)) dut_d1 (
    .clk(clk), .rst(sw_rst), .in_valid(sw_valid), .in_ctrl(sw_ctrl),
    .stall(sw_stall), .flush(sw_flush[0:0]), .out_valid(d1_ov), .out_ctrl(d1_oc),
    .stage_valid(d1_sv), .tap_reg_write(d1_tap), .occupancy(d1_occ)
  );
  wb_ctrl_pipe #(.CTRL_W(5), .DEPTH(4), .REGW_BIT(0)) dut_d4 (
    .clk(clk), .rst(sw_rst), .in_valid(sw_valid), .in_ctrl(sw_ctrl),
    .stall(sw_stall), .flush(sw_flush[3:0]), .out_valid(d4_ov), .out_ctrl(d4_oc),
    .stage_valid(d4_sv), .tap_reg_write(d4_tap), .occupancy(d4_occ)
  );
  wb_ctrl_pipe #(.CTRL_W(5), .DEPTH(8), .REGW_BIT(0)) dut_d8 (
    .clk(clk), .rst(sw_rst), .in_valid(sw_valid), .in_ctrl(sw_ctrl),
    .stall(sw_stall), .flush(sw_flush), .out_valid(d8_ov), .out_ctrl(d8_oc),
    .stage_valid(d8_sv), .tap_reg_write(d8_tap), .occupancy(d8_occ)
  );

  // Sweep snapshots {out_valid, out_ctrl, stage_valid[8], tap[8], occupancy[4]}
  wire [25:0] sn [3];
  assign sn[0] = {d1_ov, d1_oc, 8'(d1_sv), 8'(d1_tap), 4'(d1_occ)};
  assign sn[1] = {d4_ov, d4_oc, 8'(d4_sv), 8'(d4_tap), 4'(d4_occ)};
  assign sn[2] = {d8_ov, d8_oc, 8'(d8_sv), 8'(d8_tap), 4'(d8_occ)};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_ctrl = 3'b111; stall = 1'b0; flush = 2'b00;
    step();
    exp = 10'b0;
    checks++; if (snap !== exp) begin errors++; $display("FAIL reset got=%b exp=%b", snap, exp); end
    rst = 1'b0; in_valid = 1'b0; in_ctrl = 3'b000;
  endtask

  task automatic test_pass_through();
    in_valid = 1'b1; in_ctrl = 3'b101; step();
    exp = {1'b0, 3'b000, 2'b01, 2'b01, 2'd1};
    checks++; if (snap !== exp) begin errors++; $display("FAIL pass_e1 got=%b exp=%b", snap, exp); end
    in_ctrl = 3'b011; step();
    exp = {1'b1, 3'b101, 2'b11, 2'b11, 2'd2};
    checks++; if (snap !== exp) begin errors++; $display("FAIL pass_e2 got=%b exp=%b", snap, exp); end
    in_ctrl = 3'b110; step();
    exp = {1'b1, 3'b011, 2'b11, 2'b10, 2'd2};
    checks++; if (snap !== exp) begin errors++; $display("FAIL pass_e3 got=%b exp=%b", snap, exp); end
    in_ctrl = 3'b000; step();
    exp = {1'b1, 3'b110, 2'b11, 2'b00, 2'd2};
    checks++; if (snap !== exp) begin errors++; $display("FAIL pass_e4 got=%b exp=%b", snap, exp); end
    in_valid = 1'b0; step();
    exp = {1'b1, 3'b000, 2'b10, 2'b00, 2'd1};
    checks++; if (snap !== exp) begin errors++; $display("FAIL pass_drain1 got=%b exp=%b", snap, exp); end
    step();
    exp = 10'b0;
    checks++; if (snap !== exp) begin errors++; $display("FAIL pass_empty got=%b exp=%b", snap, exp); end
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_ctrl = 3'b001; step();
    exp = {1'b0, 3'b000, 2'b01, 2'b01, 2'd1};
    checks++; if (snap !== exp) begin errors++; $display("FAIL stall_load got=%b exp=%b", snap, exp); end
    stall = 1'b1; in_ctrl = 3'b010;
    for (int n = 0; n < 2; n++) begin
      step();
      checks++; if (snap !== exp) begin errors++; $display("FAIL stall_hold%0d got=%b exp=%b", n, snap, exp); end
    end
    stall = 1'b0; step();
    exp = {1'b1, 3'b001, 2'b11, 2'b10, 2'd2};
    checks++; if (snap !== exp) begin errors++; $display("FAIL stall_out1 got=%b exp=%b", snap, exp); end
    in_valid = 1'b0; in_ctrl = 3'b000; step();
    exp = {1'b1, 3'b010, 2'b10, 2'b00, 2'd1};
    checks++; if (snap !== exp) begin errors++; $display("FAIL stall_out2 got=%b exp=%b", snap, exp); end
    step();
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_ctrl = 3'b001; step();
    in_ctrl = 3'b011; step();
    exp = {1'b1, 3'b001, 2'b11, 2'b11, 2'd2};
    checks++; if (snap !== exp) begin errors++; $display("FAIL flush_fill got=%b exp=%b", snap, exp); end
    flush = 2'b01; in_ctrl = 3'b111; step();
    exp = {1'b1, 3'b011, 2'b10, 2'b10, 2'd1};
    checks++; if (snap !== exp) begin errors++; $display("FAIL flush_s0 got=%b exp=%b", snap, exp); end
    flush = 2'b00; in_valid = 1'b0; in_ctrl = 3'b000; step();
    exp = 10'b0;
    checks++; if (snap !== exp) begin errors++; $display("FAIL flush_bubble_out got=%b exp=%b", snap, exp); end
  endtask

  task automatic test_flush_stall();
    in_valid = 1'b1; in_ctrl = 3'b101; step();
    in_ctrl = 3'b001; step();
    exp = {1'b1, 3'b101, 2'b11, 2'b11, 2'd2};
    checks++; if (snap !== exp) begin errors++; $display("FAIL fstall_fill got=%b exp=%b", snap, exp); end
    stall = 1'b1; flush = 2'b10; in_ctrl = 3'b111; step();
    exp = {1'b0, 3'b000, 2'b01, 2'b01, 2'd1};
    checks++; if (snap !== exp) begin errors++; $display("FAIL fstall_s1 got=%b exp=%b", snap, exp); end
    stall = 1'b0; flush = 2'b01; in_ctrl = 3'b110; step();
    exp = {1'b1, 3'b001, 2'b10, 2'b10, 2'd1};
    checks++; if (snap !== exp) begin errors++; $display("FAIL fstall_passthru got=%b exp=%b", snap, exp); end
    flush = 2'b00; in_valid = 1'b0; in_ctrl = 3'b000; step();
    exp = 10'b0;
    checks++; if (snap !== exp) begin errors++; $display("FAIL fstall_empty got=%b exp=%b", snap, exp); end
  endtask

  task automatic test_bubble_gating();
    in_valid = 1'b1; in_ctrl = 3'b001; step();
    in_valid = 1'b0; in_ctrl = 3'bxx1; step();
    exp = {1'b1, 3'b001, 2'b10, 2'b10, 2'd1};
    checks++; if (snap !== exp) begin errors++; $display("FAIL bubble_tap got=%b exp=%b", snap, exp); end
    step();
    exp = 10'b0;
    checks++; if (snap !== exp) begin errors++; $display("FAIL bubble_out got=%b exp=%b", snap, exp); end
    in_ctrl = 3'b000;
  endtask

  task automatic test_mid_reset();
    in_valid = 1'b1; in_ctrl = 3'b011; step();
    in_ctrl = 3'b101; step();
    rst = 1'b1; in_ctrl = 3'b111; step();
    exp = 10'b0;
    checks++; if (snap !== exp) begin errors++; $display("FAIL midrst_clear got=%b exp=%b", snap, exp); end
    rst = 1'b0; in_ctrl = 3'b110; step();
    exp = {1'b0, 3'b000, 2'b01, 2'b00, 2'd1};
    checks++; if (snap !== exp) begin errors++; $display("FAIL midrst_e1 got=%b exp=%b", snap, exp); end
    in_valid = 1'b0; in_ctrl = 3'b000; step();
    exp = {1'b1, 3'b110, 2'b10, 2'b00, 2'd1};
    checks++; if (snap !== exp) begin errors++; $display("FAIL midrst_e2 got=%b exp=%b", snap, exp); end
    step();
  endtask

  // Randomised sweep against a per-depth list of (valid, ctrl) stage entries.
  task automatic test_sweep();
    int         dep [3] = '{1, 4, 8};
    logic       mv [3][8];
    logic [4:0] mc [3][8];
    logic [25:0] e;
    logic [7:0] esv, etap;
    logic [3:0] eocc;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) begin mv[k][i] = 1'b0; mc[k][i] = 5'b0; end
    sw_rst = 1'b1; sw_valid = 1'b0; sw_ctrl = 5'b0; sw_stall = 1'b0; sw_flush = 8'b0;
    step();
    for (int n = 1; n <= 400; n++) begin
      sw_rst   = (n % 97 == 0);
      sw_valid = ($urandom % 4) != 0;
      sw_ctrl  = sw_valid ? 5'($urandom) : 5'bxxxxx;
      sw_stall = ($urandom % 4) == 0;
      sw_flush = 8'($urandom & $urandom & $urandom);
      // Oldest stage first so stage i still sees the pre-edge stage i-1.
      for (int k = 0; k < 3; k++)
        for (int i = 7; i >= 0; i--)
          if (i < dep[k]) begin
            if (sw_rst || sw_flush[i]) begin
              mv[k][i] = 1'b0; mc[k][i] = 5'b0;
            end else if (!sw_stall) begin
              if (i == 0) begin
                mv[k][0] = sw_valid; mc[k][0] = sw_valid ? sw_ctrl : 5'b0;
              end else begin
                mv[k][i] = mv[k][i-1]; mc[k][i] = mc[k][i-1];
              end
            end
          end
      step();
      for (int k = 0; k < 3; k++) begin
        esv = 8'b0; etap = 8'b0; eocc = 4'd0;
        for (int i = 0; i < dep[k]; i++) begin
          esv[i]  = mv[k][i];
          etap[i] = mv[k][i] & mc[k][i][0];
          eocc    = eocc + 4'(mv[k][i]);
        end
        e = {mv[k][dep[k]-1], mc[k][dep[k]-1], esv, etap, eocc};
        checks++;
        if (sn[k] !== e) begin
          errors++;
          $display("FAIL sweep_d%0d_c%0d got=%b exp=%b", dep[k], n, sn[k], e);
        end
        checks++;
        if (32'(sn[k][3:0]) > dep[k]) begin
          errors++;
          $display("FAIL sweep_occ_bound_d%0d_c%0d got=%0d max=%0d", dep[k], n, sn[k][3:0], dep[k]);
        end
      end
    end
    sw_rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_ctrl = 3'b000; stall = 1'b0; flush = 2'b00;
    sw_rst = 1'b1; sw_valid = 1'b0; sw_ctrl = 5'b0; sw_stall = 1'b0; sw_flush = 8'b0;
    test_reset();
    test_pass_through();
    test_stall();
    test_flush();
    test_flush_stall();
    test_bubble_gating();
    test_mid_reset();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
